// File: rtl/bht_assoc_if.sv
// IF-lookup / EX-update / redirect bundle for the associative branch history table.
// The master side is the pipeline; the slave side is the table itself.
interface bht_assoc_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned STAT_W = 16
) ();
    logic [ADDR_W-1:0] IFpc;
    logic              IFpcchoose;
    logic [ADDR_W-1:0] IFnpc;
    logic              ex_valid;
    logic [ADDR_W-1:0] Expc;
    logic [ADDR_W-1:0] Exnpc;
    logic              Expcchoose;
    logic [ADDR_W-1:0] Expredpc;
    logic              isjmp;
    logic              pcclear;
    logic [ADDR_W-1:0] clear_npc;
    logic [STAT_W-1:0] mispred_cnt;

    modport master (
        output IFpc, ex_valid, Expc, Exnpc, Expcchoose, Expredpc, isjmp,
        input  IFpcchoose, IFnpc, pcclear, clear_npc, mispred_cnt
    );

    modport slave (
        input  IFpc, ex_valid, Expc, Exnpc, Expcchoose, Expredpc, isjmp,
        output IFpcchoose, IFnpc, pcclear, clear_npc, mispred_cnt
    );
endinterface

// File: rtl/bht_assoc.sv
// Fully associative branch history table: saturating counters, stored targets,
// true-LRU replacement, registered redirect and a saturating misprediction counter.
module bht_assoc #(
    parameter int unsigned ENTRIES  = 8,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned CNT_W    = 2,
    parameter int unsigned INIT_CNT = 1,
    parameter int unsigned STAT_W   = 16
) (
    input  logic           clk_sys,
    input  logic           rst_n,
    bht_assoc_if.slave     bus
);
    localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [ADDR_W-1:0]  addr_q [ENTRIES];
    logic [ADDR_W-1:0]  addr_d [ENTRIES];
    logic [ADDR_W-1:0]  tgt_q  [ENTRIES];
    logic [ADDR_W-1:0]  tgt_d  [ENTRIES];
    logic [CNT_W-1:0]   cnt_q  [ENTRIES];
    logic [CNT_W-1:0]   cnt_d  [ENTRIES];
    logic [IDX_W-1:0]   age_q  [ENTRIES];
    logic [IDX_W-1:0]   age_d  [ENTRIES];

    logic              pcclear_q, pcclear_d;
    logic [ADDR_W-1:0] clear_npc_q, clear_npc_d;
    logic [STAT_W-1:0] mispred_q, mispred_d;

    logic             lk_hit;
    logic [IDX_W-1:0] lk_idx;
    logic             ex_hit;
    logic [IDX_W-1:0] ex_idx;
    logic             vic_found;
    logic [IDX_W-1:0] vic_idx;
    logic [IDX_W-1:0] upd_idx;
    logic             touch;
    logic             redir;
    logic [ADDR_W-1:0] redir_pc;

    always_comb begin
        lk_hit = 1'b0;
        lk_idx = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && (addr_q[i] == bus.IFpc)) begin
                lk_hit = 1'b1;
                lk_idx = IDX_W'(i);
            end
        end
    end

    assign bus.IFpcchoose  = lk_hit && cnt_q[lk_idx][CNT_W-1];
    assign bus.IFnpc       = bus.IFpcchoose ? tgt_q[lk_idx] : '0;
    assign bus.pcclear     = pcclear_q;
    assign bus.clear_npc   = clear_npc_q;
    assign bus.mispred_cnt = mispred_q;

    always_comb begin
        valid_d   = valid_q;
        addr_d    = addr_q;
        tgt_d     = tgt_q;
        cnt_d     = cnt_q;
        age_d     = age_q;
        ex_hit    = 1'b0;
        ex_idx    = '0;
        vic_found = 1'b0;
        vic_idx   = '0;
        upd_idx   = '0;
        touch     = 1'b0;
        redir     = 1'b0;
        redir_pc  = clear_npc_q;

        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && (addr_q[i] == bus.Expc)) begin
                ex_hit = 1'b1;
                ex_idx = IDX_W'(i);
            end
        end

        // Victim: lowest-index invalid entry, else the oldest (age ENTRIES-1).
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (!vic_found && !valid_q[i]) begin
                vic_found = 1'b1;
                vic_idx   = IDX_W'(i);
            end
        end
        if (!vic_found) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                if (age_q[i] == IDX_W'(ENTRIES - 1)) vic_idx = IDX_W'(i);
            end
        end

        if (bus.ex_valid) begin
            if (bus.isjmp) begin
                touch   = 1'b1;
                upd_idx = ex_hit ? ex_idx : vic_idx;
                if (ex_hit) begin
                    if (cnt_q[upd_idx] != '1) cnt_d[upd_idx] = cnt_q[upd_idx] + 1'b1;
                end else begin
                    valid_d[upd_idx] = 1'b1;
                    addr_d[upd_idx]  = bus.Expc;
                    cnt_d[upd_idx]   = CNT_W'(INIT_CNT);
                end
                tgt_d[upd_idx] = bus.Exnpc;
                redir    = !bus.Expcchoose || (bus.Expredpc != bus.Exnpc);
                redir_pc = bus.Exnpc;
            end else begin
                if (ex_hit && (cnt_q[ex_idx] != '0)) cnt_d[ex_idx] = cnt_q[ex_idx] - 1'b1;
                redir    = bus.Expcchoose;
                redir_pc = bus.Expc + ADDR_W'(4);
            end
        end

        if (touch) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                if (IDX_W'(i) == upd_idx)          age_d[i] = '0;
                else if (age_q[i] < age_q[upd_idx]) age_d[i] = age_q[i] + 1'b1;
            end
        end

        pcclear_d   = redir;
        clear_npc_d = redir ? redir_pc : clear_npc_q;
        mispred_d   = (redir && (mispred_q != '1)) ? mispred_q + 1'b1 : mispred_q;
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            pcclear_q   <= 1'b0;
            clear_npc_q <= '0;
            mispred_q   <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                addr_q[i] <= '0;
                tgt_q[i]  <= '0;
                cnt_q[i]  <= '0;
                age_q[i]  <= IDX_W'(i);
            end
        end else begin
            valid_q     <= valid_d;
            addr_q      <= addr_d;
            tgt_q       <= tgt_d;
            cnt_q       <= cnt_d;
            age_q       <= age_d;
            pcclear_q   <= pcclear_d;
            clear_npc_q <= clear_npc_d;
            mispred_q   <= mispred_d;
        end
    end
endmodule

// File: doc/bht_assoc.md
# bht_assoc

Parametrised, fully associative branch history table with per-entry saturating counters, stored targets, true-LRU replacement and registered redirect generation. It sits between the IF stage, which does a combinational lookup, and the EX stage, which does a resolved-branch update. Beyond a fixed 8-entry, 2-bit table, it adds:

- configurable depth, address width and counter width;
- valid-qualified matching;
- counter decrement on not-taken branches;
- target-mismatch redirect;
- a registered redirect PC;
- a misprediction counter.

## Interface
Parameters:
- ENTRIES, 8, number of table entries, power of two, ≥2.
- ADDR_W, 32, PC and target width.
- CNT_W, 2, saturating counter width, ≥1.
- INIT_CNT, 1, counter value written on allocation, < 2^CNT_W.
- STAT_W, 16, misprediction counter width.

Ports:
- clk_sys  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- IFpc  in  ADDR_W  fetch PC to look up.
- IFpcchoose  out  1  combinational; hit with counter MSB = 1 (predict taken).
- IFnpc  out  ADDR_W  combinational; stored target when IFpcchoose = 1, else 0.
- ex_valid  in  1  qualifies all Ex* inputs and isjmp.
- Expc  in  ADDR_W  PC of the resolved branch.
- Exnpc  in  ADDR_W  resolved taken target.
- Expcchoose  in  1  IF prediction carried to EX (1 = predicted taken).
- Expredpc  in  ADDR_W  predicted target carried to EX.
- isjmp  in  1  branch resolved taken.
- pcclear  out  1  registered; flush/redirect strobe.
- clear_npc  out  ADDR_W  registered; redirect PC, valid when pcclear = 1.
- mispred_cnt  out  STAT_W  saturating count of pcclear assertions.

## Operation
Entry state:
- valid, addr[ADDR_W], target[ADDR_W], cnt[CNT_W].
- age[clog2(ENTRIES)]: ages always form a permutation of 0..ENTRIES-1.

Matching:
- An entry matches only if valid = 1 and addr equals the PC.
- At most one entry ever matches, because allocation happens only on a miss.

Lookup:
- Purely combinational from IFpc and the current registered state.
- An update in the same cycle is not visible until the following cycle; there is no bypass.

Update, only when ex_valid = 1, by case:
- isjmp = 1, Expcchoose = 0 (taken, not predicted):
  - Hit: cnt = sat(cnt+1), target = Exnpc, touch.
  - Miss: allocate with addr = Expc, target = Exnpc, cnt = INIT_CNT, valid = 1, touch.
  - Redirect to Exnpc.
- isjmp = 1, Expcchoose = 1 (taken, predicted taken):
  - Hit: cnt = sat(cnt+1), target = Exnpc, touch.
  - Miss (entry evicted meanwhile): allocate as above.
  - Redirect to Exnpc only if Expredpc ≠ Exnpc.
- isjmp = 0, Expcchoose = 0: hit gives cnt = sat(cnt-1); no touch, no redirect.
- isjmp = 0, Expcchoose = 1: hit gives cnt = sat(cnt-1); no touch; redirect to Expc+4 (modulo 2^ADDR_W).

Saturation:
- cnt is bounded at 0 and 2^CNT_W-1.
- A miss on a not-taken branch never allocates.

Touch (true LRU):
- The entry with old age a gets age 0.
- Every entry with age < a increments.
- All others are unchanged.

Victim selection:
- The lowest-index invalid entry if any exists.
- Otherwise the entry with age = ENTRIES-1.

Redirect:
- pcclear and clear_npc load on the edge that samples the update.
- pcclear = 0 when there is no redirect or ex_valid = 0.
- clear_npc holds its last value when pcclear = 0.

mispred_cnt:
- Increments on every edge that sets pcclear = 1.
- Saturates at 2^STAT_W-1.

Reset (rst_n low, asynchronous, overrides everything):
- valid = 0, addr = 0, target = 0, cnt = 0, age[i] = i.
- pcclear = 0, clear_npc = 0, mispred_cnt = 0.
- IFpcchoose = 0 and IFnpc = 0 follow from all entries being invalid.
- A reset asserted mid-update discards that update.

## Timing
- Lookup: 0-cycle latency, combinational from IFpc.
- Update: the effect is visible to lookup in cycle N+1 after the edge at the end of cycle N.
- pcclear: high for exactly one cycle (N+1) per redirecting update; back-to-back redirecting updates give back-to-back pcclear pulses.
- Reset deassertion: first update is accepted on the first rising edge with rst_n high; no synchronisation stage inside the block.
- Lookup and update to the same PC in the same cycle: lookup returns pre-update state.

## Test plan
- Reset, then IFpc = 0x0 → IFpcchoose = 0, IFnpc = 0. This shows address 0 does not hit an invalid entry.
- ENTRIES = 4, INIT_CNT = 1. Taken unpredicted branch, Expc = 0x100, Exnpc = 0x200:
  - next cycle pcclear = 1, clear_npc = 0x200, mispred_cnt = 1;
  - IFpc = 0x100 → IFpcchoose = 0 (cnt = 1);
  - second identical update → cnt = 2, IFpcchoose = 1, IFnpc = 0x200.
- Counter saturation: drive four taken updates on 0x100 → cnt = 3; then five not-taken updates with Expcchoose = 0 → cnt = 0, no pcclear, no underflow to 3.
- Predicted taken, actually not taken: Expc = 0x100, Expredpc = 0x200, isjmp = 0 → pcclear = 1, clear_npc = 0x104. Same case with Expc = 0xFFFFFFFC → clear_npc = 0x0 (wrap).
- Target change: hit on 0x100 with Expcchoose = 1, Expredpc = 0x200, Exnpc = 0x300 → pcclear = 1, clear_npc = 0x300, then IFnpc = 0x300. With Expredpc = Exnpc = 0x300 → pcclear = 0.
- LRU, ENTRIES = 4:
  - allocate 0x10, 0x20, 0x30, 0x40;
  - re-hit 0x10 with a taken update;
  - allocate 0x50 → 0x20 evicted, 0x10 still hits;
  - assert rst_n low mid-sequence → all lookups miss, mispred_cnt = 0.
